// File: rtl/dmem_arbiter.sv
// Two-port req/ack arbiter for the 1Kx32 big-endian data memory.
// It runs one word access at a time as IDLE -> ACCESS -> DONE, three cycles per access.
module dmem_arbiter #(
   parameter int unsigned MEM_BYTES  = 4096,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        p0_req,
   input  logic        p0_wr,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic [31:0] p0_rdata,
   output logic        p0_ack,
   output logic        p0_err,
   input  logic        p1_req,
   input  logic        p1_wr,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic [31:0] p1_rdata,
   output logic        p1_ack,
   output logic        p1_err,
   output logic        busy,
   output logic        dm_cs,
   output logic        dm_rd,
   output logic        dm_wr,
   output logic [31:0] addr,
   output logic [31:0] D_in,
   input  logic [31:0] D_out_mem
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

   localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

   state_e      state_q;
   logic        grant_q, last_grant_q, wr_q;
   logic [31:0] addr_q, wdata_q, rdata0_q, rdata1_q;
   logic        ack0_q, ack1_q, err0_q, err1_q;
   logic        cs_q, rd_q, we_q;

   logic        pick1, sel_wr, sel_legal;
   logic [31:0] sel_addr, sel_wdata;

   // On a tie, round-robin favours the port that did not win last time.
   always_comb begin
      if (p0_req && p1_req) pick1 = FIXED_PRIO ? 1'b0 : ~last_grant_q;
      else                  pick1 = p1_req;
      sel_wr    = pick1 ? p1_wr    : p0_wr;
      sel_addr  = pick1 ? p1_addr  : p0_addr;
      sel_wdata = pick1 ? p1_wdata : p0_wdata;
      sel_legal = (sel_addr[1:0] == 2'b00) && (sel_addr <= LAST_WORD);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
         cs_q         <= 1'b0;
         rd_q         <= 1'b0;
         we_q         <= 1'b0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         err0_q <= 1'b0;
         err1_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (p0_req || p1_req) begin
                  grant_q      <= pick1;
                  last_grant_q <= pick1;
                  wr_q         <= sel_wr;
                  addr_q       <= sel_addr;
                  wdata_q      <= sel_wdata;
                  if (sel_legal) begin
                     state_q <= ACCESS;
                     cs_q    <= 1'b1;
                     rd_q    <= ~sel_wr;
                     we_q    <= sel_wr;
                  end else begin
                     // Illegal address: go straight to the error ack with no memory strobe.
                     state_q <= DONE;
                     ack0_q  <= ~pick1;
                     ack1_q  <= pick1;
                     err0_q  <= ~pick1;
                     err1_q  <= pick1;
                  end
               end
            end
            ACCESS: begin
               state_q <= DONE;
               cs_q    <= 1'b0;
               rd_q    <= 1'b0;
               we_q    <= 1'b0;
               ack0_q  <= ~grant_q;
               ack1_q  <= grant_q;
               if (!wr_q) begin
                  if (grant_q) rdata1_q <= D_out_mem;
                  else         rdata0_q <= D_out_mem;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = (state_q != IDLE);
   assign dm_cs    = cs_q;
   assign dm_rd    = rd_q;
   assign dm_wr    = we_q;
   assign addr     = addr_q;
   assign D_in     = wdata_q;
   assign p0_rdata = rdata0_q;
   assign p1_rdata = rdata1_q;
   assign p0_ack   = ack0_q;
   assign p1_ack   = ack1_q;
   assign p0_err   = err0_q;
   assign p1_err   = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a byte-level big-endian memory model predicts each transaction.
// A monitor checks the strobes and acks that the DUT actually presents.
module tb_dmem_arbiter;
   localparam int unsigned MEM_BYTES = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        p0_req, p0_wr, p1_req, p1_wr;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [31:0] p0_rdata, p1_rdata, addr, D_in;
   logic        p0_ack, p0_err, p1_ack, p1_err, busy, dm_cs, dm_rd, dm_wr;
   wire  [31:0] D_out_mem;

   logic        f_p0_req, f_p0_wr, f_p1_req, f_p1_wr;
   logic [31:0] f_p0_addr, f_p0_wdata, f_p1_addr, f_p1_wdata;
   logic [31:0] f_p0_rdata, f_p1_rdata, f_addr, f_D_in, f_dout;
   logic        f_p0_ack, f_p0_err, f_p1_ack, f_p1_err, f_busy, f_cs, f_rd, f_wr;

   dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .FIXED_PRIO(1'b0)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
      .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
      .busy(busy), .dm_cs(dm_cs), .dm_rd(dm_rd), .dm_wr(dm_wr),
      .addr(addr), .D_in(D_in), .D_out_mem(D_out_mem));

   dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .FIXED_PRIO(1'b1)) u_fp (
      .clk(clk), .reset_n(reset_n),
      .p0_req(f_p0_req), .p0_wr(f_p0_wr), .p0_addr(f_p0_addr), .p0_wdata(f_p0_wdata),
      .p0_rdata(f_p0_rdata), .p0_ack(f_p0_ack), .p0_err(f_p0_err),
      .p1_req(f_p1_req), .p1_wr(f_p1_wr), .p1_addr(f_p1_addr), .p1_wdata(f_p1_wdata),
      .p1_rdata(f_p1_rdata), .p1_ack(f_p1_ack), .p1_err(f_p1_err),
      .busy(f_busy), .dm_cs(f_cs), .dm_rd(f_rd), .dm_wr(f_wr),
      .addr(f_addr), .D_in(f_D_in), .D_out_mem(f_dout));
   assign f_dout = 32'h0;

   // Device memory: big-endian bytes, combinational read, write on the clock edge.
   logic [7:0]  dev_mem [MEM_BYTES];
   logic [11:0] dai;
   assign dai = addr[11:0];
   assign D_out_mem = (dm_cs && dm_rd) ?
      {dev_mem[dai], dev_mem[dai + 12'd1], dev_mem[dai + 12'd2], dev_mem[dai + 12'd3]} : 'z;
   always @(posedge clk) begin
      if (dm_cs && dm_wr) begin
         dev_mem[dai]         <= D_in[31:24];
         dev_mem[dai + 12'd1] <= D_in[23:16];
         dev_mem[dai + 12'd2] <= D_in[15:8];
         dev_mem[dai + 12'd3] <= D_in[7:0];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          port;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          err;
      logic [31:0] rdata;
      int          ack_cyc;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  ref_mem [MEM_BYTES];
   logic [31:0] last_rd [2];
   int          last_g;
   int          n_total = 0;
   int          n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (a < MEM_BYTES);
   endfunction

   task automatic model_txn(input int port, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input int ack_cyc);
      exp_t e;
      int   i;
      e.port = port; e.wr = wr; e.addr = a; e.wdata = d; e.err = !legal(a);
      if (!e.err) begin
         i = int'(a);
         if (wr) begin
            ref_mem[i] = d[31:24]; ref_mem[i+1] = d[23:16];
            ref_mem[i+2] = d[15:8]; ref_mem[i+3] = d[7:0];
         end else begin
            last_rd[port] = {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
         end
      end
      e.rdata   = last_rd[port];
      e.ack_cyc = ack_cyc;
      last_g    = port;
      sb.push_back(e);
   endtask

   function automatic int dur(input logic [31:0] a);
      return legal(a) ? 3 : 2;
   endfunction

   // One arbitration round on the round-robin DUT; each requester drops req on its ack.
   task automatic round(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                        input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
      int first, c;
      bit done0, done1;
      @(negedge clk);
      c = cyc;
      if (r0 && r1) first = (last_g == 1) ? 0 : 1;
      else          first = r0 ? 0 : 1;
      if (first == 0) begin
         model_txn(0, w0, a0, d0, c + dur(a0) - 1);
         if (r1) model_txn(1, w1, a1, d1, c + dur(a0) + dur(a1) - 1);
      end else begin
         model_txn(1, w1, a1, d1, c + dur(a1) - 1);
         if (r0) model_txn(0, w0, a0, d0, c + dur(a1) + dur(a0) - 1);
      end
      p0_req = r0; p0_wr = w0; p0_addr = a0; p0_wdata = d0;
      p1_req = r1; p1_wr = w1; p1_addr = a1; p1_wdata = d1;
      done0 = !r0; done1 = !r1;
      for (int k = 0; k < 20 && !(done0 && done1); k++) begin
         @(negedge clk);
         if (k == 0) begin
            // The winner is already latched; scrambling its fields must have no effect.
            if (first == 0) begin p0_addr = $urandom; p0_wdata = $urandom; p0_wr = !w0; end
            else            begin p1_addr = $urandom; p1_wdata = $urandom; p1_wr = !w1; end
         end
         if (p0_ack) begin p0_req = 1'b0; done0 = 1'b1; end
         if (p1_ack) begin p1_req = 1'b0; done1 = 1'b1; end
      end
      chk("round_done", 32'(done0 && done1), 32'd1);
      if (!(done0 && done1)) begin
         p0_req = 1'b0; p1_req = 1'b0;
         sb.delete();
      end
   endtask

   // Both ports hold req high with writes; grants must alternate.
   task automatic held_both(input int n);
      int first, c, acks, p;
      @(negedge clk);
      c = cyc;
      first = (last_g == 1) ? 0 : 1;
      for (int i = 0; i < n; i++) begin
         p = first ^ (i % 2);
         model_txn(p, 1'b1, (p == 1) ? 32'h0300 : 32'h0304,
                   (p == 1) ? 32'hB1B1_0001 : 32'hA0A0_0000, c + 2 + 3 * i);
      end
      p0_req = 1'b1; p0_wr = 1'b1; p0_addr = 32'h0304; p0_wdata = 32'hA0A0_0000;
      p1_req = 1'b1; p1_wr = 1'b1; p1_addr = 32'h0300; p1_wdata = 32'hB1B1_0001;
      acks = 0;
      for (int k = 0; k < 40 && acks < n; k++) begin
         @(negedge clk);
         if (p0_ack) begin if (acks >= n - 2) p0_req = 1'b0; acks++; end
         if (p1_ack) begin if (acks >= n - 2) p1_req = 1'b0; acks++; end
      end
      chk("held_acks", 32'(acks), 32'(n));
      p0_req = 1'b0; p1_req = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned k, w;
      k = $urandom_range(0, 9);
      w = $urandom_range(0, 15);
      case (k)
         0:       return 32'h0200 + 32'(w * 4) + 32'($urandom_range(1, 3));
         1:       return 32'h1000 + 32'(w * 4);
         2:       return 32'hFFFF_FFFC;
         3:       return 32'h0000_0FFC;
         default: return 32'h0200 + 32'(w * 4);
      endcase
   endfunction

   // Monitor: every strobe and ack is matched against the head of the scoreboard.
   int cs_seen = 0;
   initial begin
      exp_t e;
      int   ap;
      forever begin
         @(negedge clk);
         if (p0_err) chk("p0_err_needs_ack", 32'(p0_ack), 32'd1);
         if (p1_err) chk("p1_err_needs_ack", 32'(p1_ack), 32'd1);
         if (dm_cs) begin
            cs_seen++;
            chk("cs_has_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb[0];
               chk("cs_addr_legal", 32'(e.err), 32'd0);
               chk("dm_addr", addr, e.addr);
               chk("dm_wr", 32'(dm_wr), 32'(e.wr));
               chk("dm_rd", 32'(dm_rd), 32'(!e.wr));
               if (e.wr) chk("D_in", D_in, e.wdata);
            end
         end
         if (p0_ack || p1_ack) begin
            chk("ack_exclusive", 32'(p0_ack && p1_ack), 32'd0);
            chk("cs_low_at_ack", 32'(dm_cs), 32'd0);
            chk("ack_has_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e  = sb.pop_front();
               ap = p1_ack ? 1 : 0;
               chk("ack_port", 32'(ap), 32'(e.port));
               chk("err", 32'((ap == 1) ? p1_err : p0_err), 32'(e.err));
               chk("rdata", (ap == 1) ? p1_rdata : p0_rdata, e.rdata);
               chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
               chk("strobe_cycles", 32'(cs_seen), e.err ? 32'd0 : 32'd1);
            end
            cs_seen = 0;
         end
      end
   end

   initial begin
      int n0, sel;
      bit got;
      for (int i = 0; i < int'(MEM_BYTES); i++) begin ref_mem[i] = 8'h00; dev_mem[i] = 8'h00; end
      last_rd[0] = '0; last_rd[1] = '0; last_g = 1;
      p0_req = 0; p0_wr = 0; p0_addr = '0; p0_wdata = '0;
      p1_req = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0;
      f_p0_req = 0; f_p0_wr = 1; f_p0_addr = 32'h40; f_p0_wdata = 32'h0F0F_0F0F;
      f_p1_req = 0; f_p1_wr = 1; f_p1_addr = 32'h44; f_p1_wdata = 32'hF0F0_F0F0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cs", 32'(dm_cs), 32'd0);
      chk("rst_rd", 32'(dm_rd), 32'd0);
      chk("rst_wr", 32'(dm_wr), 32'd0);
      chk("rst_acks", 32'({p0_ack, p1_ack, p0_err, p1_err}), 32'd0);
      chk("rst_addr", addr, 32'd0);
      chk("rst_din", D_in, 32'd0);
      chk("rst_rdata0", p0_rdata, 32'd0);
      chk("rst_rdata1", p1_rdata, 32'd0);
      reset_n = 1'b1;

      round(1, 1, 32'h010, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0);
      round(1, 0, 32'h010, 32'h0,         0, 0, 32'h0, 32'h0);
      round(1, 0, 32'h010, 32'h0,         1, 1, 32'h014, 32'h1357_9BDF);
      held_both(6);
      round(0, 0, 32'h0, 32'h0, 1, 0, 32'h010, 32'h0);
      round(0, 0, 32'h0, 32'h0, 1, 0, 32'h002, 32'h0);
      round(0, 0, 32'h0, 32'h0, 1, 0, 32'h1000, 32'h0);
      round(1, 1, 32'h0FFC, 32'h1234_5678, 0, 0, 32'h0, 32'h0);
      round(1, 0, 32'h0FFC, 32'h0,         0, 0, 32'h0, 32'h0);
      chk("be_byte_ffc", 32'(dev_mem[12'hFFC]), 32'h12);
      chk("be_byte_fff", 32'(dev_mem[12'hFFF]), 32'h78);
      round(1, 0, 32'hFFFF_FFFC, 32'h0, 1, 1, 32'h0FFE, 32'h0);

      round(1, 1, 32'h020, 32'hAAAA_AAAA, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      p0_req = 1'b1; p0_wr = 1'b1; p0_addr = 32'h020; p0_wdata = 32'h5555_5555;
      @(posedge clk);
      #1;
      chk("abort_in_access", 32'(dm_cs && dm_wr), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cs", 32'(dm_cs), 32'd0);
      chk("abort_wr", 32'(dm_wr), 32'd0);
      p0_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_no_ack", 32'({p0_ack, p1_ack}), 32'd0);
      chk("abort_rdata", p0_rdata, 32'd0);
      last_rd[0] = '0; last_rd[1] = '0; last_g = 1;
      reset_n = 1'b1;
      round(1, 0, 32'h020, 32'h0, 0, 0, 32'h0, 32'h0);

      for (int r = 0; r < 120; r++) begin
         sel = int'($urandom_range(1, 3));
         round(sel[0], 1'($urandom_range(0, 1)), rand_addr(), $urandom,
               sel[1], 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      // Fixed priority: port 1 must starve while port 0 keeps requesting.
      @(negedge clk);
      f_p0_req = 1'b1; f_p1_req = 1'b1;
      n0 = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         chk("fp_p1_starved", 32'(f_p1_ack), 32'd0);
         if (f_p0_ack) n0++;
      end
      chk("fp_p0_served", 32'(n0 >= 4), 32'd1);
      got = 1'b0;
      for (int k = 0; k < 6 && !got; k++) begin
         if (f_p0_ack) begin f_p0_req = 1'b0; got = 1'b1; end
         else @(negedge clk);
      end
      f_p0_req = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (f_p1_ack) begin got = 1'b1; f_p1_req = 1'b0; end
      end
      chk("fp_p1_after_p0", 32'(got), 32'd1);
      f_p1_req = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
